// File: rtl/pu_compare_ctrl.sv
// rtl/pu_compare_ctrl.sv - round-robin arbiter and write/oe sequencer sharing one pu_compare
// All outputs are registered and decoded from the next state, so each output reflects the state it is shown in.
module pu_compare_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int SEL_WIDTH  = 3,
  parameter int NREQ       = 4,
  parameter int ID_WIDTH   = 2,
  parameter int OE_LAT     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*SEL_WIDTH-1:0]  req_op,
  input  logic [NREQ*DATA_WIDTH-1:0] req_a,
  input  logic [NREQ*DATA_WIDTH-1:0] req_b,
  output logic [NREQ-1:0]            req_ready,
  output logic                       rsp_valid,
  output logic [ID_WIDTH-1:0]        rsp_id,
  output logic                       rsp_data,
  output logic                       rsp_err,
  input  logic                       rsp_ready,
  output logic                       busy,
  output logic                       pu_wr,
  output logic                       pu_oe,
  output logic [DATA_WIDTH-1:0]      pu_data_in,
  output logic [ATTR_WIDTH-1:0]      pu_attr_in,
  output logic [SEL_WIDTH-1:0]       pu_op_sel,
  input  logic [DATA_WIDTH-1:0]      pu_data_out,
  input  logic [ATTR_WIDTH-1:0]      pu_attr_out
);
  localparam int CW = (OE_LAT > 1) ? $clog2(OE_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(OE_LAT - 1);
  localparam logic [SEL_WIDTH-1:0] OP_MAX = SEL_WIDTH'(4);

  typedef enum logic [2:0] {S_IDLE, S_ACK, S_WR_A, S_WR_B, S_GAP, S_OE, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d, id_q, gnt_id;
  logic [SEL_WIDTH-1:0]  op_q, gnt_op;
  logic [DATA_WIDTH-1:0] a_q, b_q, gnt_a, gnt_b;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NREQ-1:0]       gnt_vec;
  logic                  gnt_found;
  logic                  op_bad;

  logic [NREQ-1:0]       rdy_d;
  logic                  rv_d, rdat_d, rerr_d, busy_d, wr_d, oe_d;
  logic [ID_WIDTH-1:0]   rid_d;
  logic [DATA_WIDTH-1:0] din_d;
  logic [SEL_WIDTH-1:0]  sel_d;

  logic unused_inputs;
  assign unused_inputs = ^{pu_data_out[DATA_WIDTH-1:1], pu_attr_out};
  assign pu_attr_in    = '0;
  assign op_bad        = (op_q > OP_MAX);

  // Priority is the circular distance from ptr; the nearest valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    ptr_d     = ptr_q;
    gnt_vec   = '0;
    gnt_op    = '0;
    gnt_a     = '0;
    gnt_b     = '0;
    for (int d = 0; d < NREQ; d++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!gnt_found && req_valid[j] && (((j - int'(ptr_q)) + NREQ) % NREQ == d)) begin
          gnt_found  = 1'b1;
          gnt_id     = ID_WIDTH'(j);
          ptr_d      = ID_WIDTH'((j + 1) % NREQ);
          gnt_vec[j] = 1'b1;
          gnt_op     = req_op[j*SEL_WIDTH +: SEL_WIDTH];
          gnt_a      = req_a[j*DATA_WIDTH +: DATA_WIDTH];
          gnt_b      = req_b[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (gnt_found) state_d = S_ACK;
      S_ACK:  state_d = op_bad ? S_RESP : S_WR_A;
      S_WR_A: state_d = S_WR_B;
      S_WR_B: state_d = S_GAP;
      S_GAP: begin
        state_d = S_OE;
        cnt_d   = CNT_LOAD;
      end
      S_OE: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rdy_d  = (state_d == S_ACK) ? gnt_vec : '0;
    wr_d   = (state_d == S_WR_A) || (state_d == S_WR_B);
    oe_d   = (state_d == S_OE);
    din_d  = (state_d == S_WR_A) ? a_q : (state_d == S_WR_B) ? b_q : '0;
    sel_d  = (state_d inside {S_WR_A, S_WR_B, S_GAP, S_OE}) ? op_q : '0;
    busy_d = (state_d != S_IDLE);
    rv_d   = (state_d == S_RESP);
    rid_d  = rv_d ? id_q : '0;
    rerr_d = rv_d && op_bad;
    // Leaving OE is the last oe cycle, so the PU result is captured exactly then.
    rdat_d = rv_d ? ((state_q == S_OE) ? pu_data_out[0] : rsp_data) : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      id_q       <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      req_ready  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= 1'b0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      pu_wr      <= 1'b0;
      pu_oe      <= 1'b0;
      pu_data_in <= '0;
      pu_op_sel  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && gnt_found) begin
        ptr_q <= ptr_d;
        id_q  <= gnt_id;
        op_q  <= gnt_op;
        a_q   <= gnt_a;
        b_q   <= gnt_b;
      end
      req_ready  <= rdy_d;
      rsp_valid  <= rv_d;
      rsp_id     <= rid_d;
      rsp_data   <= rdat_d;
      rsp_err    <= rerr_d;
      busy       <= busy_d;
      pu_wr      <= wr_d;
      pu_oe      <= oe_d;
      pu_data_in <= din_d;
      pu_op_sel  <= sel_d;
    end
  end
endmodule

// File: tb/tb_pu_compare_ctrl.sv
// tb/tb_pu_compare_ctrl.sv - directed and randomized self-checking bench for pu_compare_ctrl
module tb_pu_compare_ctrl;
  localparam int DW = 32, AW = 4, SW = 3, NREQ = 4, IW = 2, OE_LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*SW-1:0] req_op;
  logic [NREQ*DW-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid, rsp_data, rsp_err, rsp_ready, busy;
  logic [IW-1:0]     rsp_id;
  logic              pu_wr, pu_oe;
  logic [DW-1:0]     pu_data_in, pu_data_out;
  logic [AW-1:0]     pu_attr_in, pu_attr_out;
  logic [SW-1:0]     pu_op_sel;

  always #5 clk = ~clk;

  pu_compare_ctrl #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .SEL_WIDTH(SW), .NREQ(NREQ),
                    .ID_WIDTH(IW), .OE_LAT(OE_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready), .busy(busy), .pu_wr(pu_wr), .pu_oe(pu_oe),
    .pu_data_in(pu_data_in), .pu_attr_in(pu_attr_in), .pu_op_sel(pu_op_sel),
    .pu_data_out(pu_data_out), .pu_attr_out(pu_attr_out));

  int checks = 0, passes = 0, fails = 0;
  int mptr = 0;
  logic [SW-1:0] m_op [NREQ];
  logic [DW-1:0] m_a  [NREQ];
  logic [DW-1:0] m_b  [NREQ];

  // {err, result} straight from the operation table
  function automatic logic [1:0] ref_rsp(input logic [SW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd0: return {1'b0, a == b};
      3'd1: return {1'b0, a < b};
      3'd2: return {1'b0, a <= b};
      3'd3: return {1'b0, a > b};
      3'd4: return {1'b0, a >= b};
      default: return 2'b10;
    endcase
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++)
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return 0;
  endfunction

  // Behavioural PU: first write is operand a with op, second is b; result shown while oe.
  bit            prev_wr = 1'b0;
  logic [DW-1:0] pa = '0, pb = '0;
  logic [SW-1:0] pop = '0;
  logic [1:0]    pu_r;
  always_ff @(posedge clk) begin
    prev_wr <= pu_wr;
    if (pu_wr && !prev_wr) begin
      pa  <= pu_data_in;
      pop <= pu_op_sel;
    end else if (pu_wr) begin
      pb <= pu_data_in;
    end
  end
  assign pu_r        = ref_rsp(pop, pa, pb);
  assign pu_data_out = pu_oe ? {{(DW-1){1'b0}}, pu_r[0]} : '0;
  assign pu_attr_out = 4'h5;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [SW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    m_op[i] = op;
    m_a[i]  = a;
    m_b[i]  = b;
    req_op[i*SW +: SW] = op;
    req_a[i*DW +: DW]  = a;
    req_b[i*DW +: DW]  = b;
  endtask

  // One complete command: grant, PU sequence, response held for 'hold' cycles, handshake.
  task automatic do_txn(input int hold, output int wait_cyc);
    int g, lat, wr_n, oe_n;
    logic [1:0] er;
    logic [SW-1:0] op;
    logic [DW-1:0] a, b;
    logic [NREQ-1:0] exp_v;
    g = model_grant(req_valid, mptr);
    exp_v = '0;
    exp_v[g] = 1'b1;
    wait_cyc = 0;
    while (req_ready == '0 && wait_cyc < 30) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("grant", req_ready, exp_v);
    chk("busy_on_grant", busy, 1);
    mptr = (g + 1) % NREQ;
    op = m_op[g];
    a  = m_a[g];
    b  = m_b[g];
    er = ref_rsp(op, a, b);
    lat = 0; wr_n = 0; oe_n = 0;
    while (!rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
      if (pu_wr) begin
        wr_n++;
        chk(wr_n == 1 ? "wr_a_data" : "wr_b_data", pu_data_in, wr_n == 1 ? a : b);
        chk("wr_op_sel", pu_op_sel, op);
      end
      if (pu_oe) oe_n++;
    end
    chk("latency", lat, er[1] ? 1 : 4 + OE_LAT);
    chk("wr_cycles", wr_n, er[1] ? 0 : 2);
    chk("oe_cycles", oe_n, er[1] ? 0 : OE_LAT);
    chk("rsp_id", rsp_id, g);
    chk("rsp_data", rsp_data, er[0]);
    chk("rsp_err", rsp_err, er[1]);
    rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_id", rsp_id, g);
      chk("hold_data", rsp_data, er[0]);
      chk("hold_err", rsp_err, er[1]);
      chk("hold_no_grant", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_op_sel", pu_op_sel, 0);
  endtask

  initial begin
    int w, n;
    logic [3:0] mask;
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy, pu_wr, pu_oe, pu_op_sel, pu_attr_in}, 0);
    chk("reset_data_in", pu_data_in, 0);
    rst = 1'b0;

    // Single EQ request
    set_req(0, 3'd0, 32'd10, 32'd10);
    req_valid = 4'b0001;
    do_txn(0, w);
    chk("t1_wait", w, 1);
    req_valid = '0;

    // Same requester twice, re-granted on the next IDLE pass
    set_req(2, 3'd1, 32'd5, 32'd10);
    req_valid = 4'b0100;
    do_txn(0, w);
    set_req(2, 3'd1, 32'd10, 32'd5);
    do_txn(0, w);
    chk("t2_regrant", w, 1);
    req_valid = '0;

    // Invalid op bypasses the PU
    set_req(1, 3'd7, 32'd1, 32'd2);
    req_valid = 4'b0010;
    do_txn(0, w);
    req_valid = '0;

    // Stalled response while requester 3 waits
    set_req(2, 3'd0, 32'd3, 32'd3);
    set_req(3, 3'd2, 32'd1, 32'd2);
    req_valid = 4'b1100;
    do_txn(10, w);
    req_valid = 4'b1000;
    do_txn(0, w);
    chk("t5_grant_gap", w, 1);

    // Reset during OE drops the command
    set_req(2, 3'd3, 32'd9, 32'd1);
    req_valid = 4'b0100;
    n = 0;
    while (!pu_oe && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_oe", pu_oe, 1);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("t6_reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy, pu_wr, pu_oe, pu_op_sel}, 0);
    chk("t6_reset_data_in", pu_data_in, 0);
    rst = 1'b0;
    mptr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_pu_quiet", {pu_wr, pu_oe, rsp_valid}, 0);
    end

    // All requesters continuously valid: order 0,1,2,3,0
    set_req(0, 3'd3, 32'd20, 32'd15);
    set_req(1, 3'd3, 32'd15, 32'd20);
    set_req(2, 3'd2, 32'd10, 32'd10);
    set_req(3, 3'd4, 32'd10, 32'd10);
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) do_txn(0, w);

    // Randomized commands, masks and response stalls
    for (int t = 0; t < 40; t++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++)
        set_req(i,
                ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7)),
                ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 3)));
      req_valid = mask;
      do_txn($urandom_range(0, 3), w);
    end
    req_valid = '0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
